// File: rtl/snes_responder.sv
// snes_responder: SNES controller responder. Latches the 12 button bits on the
// host latch strobe and shifts them out active-low, one bit per host pulse.
// Ports: clk, rst_btn (sync, active-low), latch/pulse (async host strobes),
//        buttons[11:0] (1 = pressed) -> data, busy, frame_done, frame_abort, bit_idx.
// Latency: a pin edge on latch/pulse reaches data SYNC_STAGES+2 cycles later
// (SYNC_STAGES sync flops, one edge flop / FSM register, one output register).
// No backpressure: host strobes are consumed as they arrive.
module snes_responder #(
  parameter int SYNC_STAGES = 2,   // legal range 2-4
  parameter int FRAME_BITS  = 16   // legal range 12-16
) (
  input  logic        clk,
  input  logic        rst_btn,
  input  logic        latch,
  input  logic        pulse,
  input  logic [11:0] buttons,
  output logic        data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [4:0]  bit_idx
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);
  localparam logic [4:0] END_IDX  = 5'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   latch_prev_q;
  logic                   pulse_prev_q;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pulse_rise;

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse};
      latch_prev_q <= latch_s;
      pulse_prev_q <= pulse_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
  // Edge flops clear on reset, so a latch held high through reset release
  // shows up as a rising edge once it has crossed the synchronizer.
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign pulse_rise = pulse_s & ~pulse_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [11:0] snap_q, snap_d;
  logic        done_ev_q, done_ev_d;
  logic        abort_ev_q, abort_ev_d;

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      done_ev_q  <= 1'b0;
      abort_ev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      done_ev_q  <= done_ev_d;
      abort_ev_q <= abort_ev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    done_ev_d  = 1'b0;
    abort_ev_d = 1'b0;

    // Latch rising edge restarts the frame from any state and takes priority
    // over a coincident pulse edge, which is simply dropped.
    if (latch_rise) begin
      state_d    = LOAD;
      idx_d      = '0;
      snap_d     = buttons;
      abort_ev_d = (state_q == SHIFT);
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        LOAD: begin
          // Keep sampling while latch is high; on the falling edge the value
          // captured on the previous cycle is left frozen.
          if (latch_fall) begin
            state_d = SHIFT;
          end else begin
            snap_d = buttons;
          end
        end
        SHIFT: begin
          if (pulse_rise) begin
            if (idx_q == LAST_IDX) begin
              state_d   = DONE;
              idx_d     = END_IDX;
              done_ev_d = 1'b1;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Wire value for the current state/index
  // ---------------------------------------------------------------------------
  // Bits past the 12 buttons always read as released (1).
  logic [15:0] wire_vec;
  logic        wire_bit;

  assign wire_vec = {4'hF, ~snap_q};

  always_comb begin
    wire_bit = 1'b1;
    unique case (state_q)
      IDLE:    wire_bit = 1'b1;
      LOAD:    wire_bit = ~buttons[0];
      SHIFT:   wire_bit = wire_vec[idx_q[3:0]];
      DONE:    wire_bit = 1'b0;
      default: wire_bit = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register stage: keeps data, bit_idx, busy and the event pulses
  // aligned with each other.
  // ---------------------------------------------------------------------------
  logic       data_q;
  logic       busy_q;
  logic       frame_done_q;
  logic       frame_abort_q;
  logic [4:0] bit_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      data_q        <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      bit_idx_q     <= '0;
    end else begin
      data_q        <= wire_bit;
      busy_q        <= (state_q == LOAD) || (state_q == SHIFT);
      frame_done_q  <= done_ev_q;
      frame_abort_q <= abort_ev_q;
      bit_idx_q     <= idx_q;
    end
  end

  assign data        = data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign bit_idx     = bit_idx_q;

endmodule

// File: doc/snes_responder.md
SNES_RESPONDER -- requirements
Module: snes_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops on latch and pulse; legal range 2-4.
REQ-002 Parameter FRAME_BITS, default 16: serial bits per frame; legal range 12-16.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_btn  input  1  reset, synchronous, active-low.
REQ-005 latch  input  1  host latch strobe, asynchronous to clk, active-high.
REQ-006 pulse  input  1  host shift clock, asynchronous to clk; a rising edge advances one bit.
REQ-007 buttons  input  12  button state, 1 = pressed; bit order B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R (bit0 = B).
REQ-008 data  output  1  serial line to host, registered, active-low (0 = pressed).
REQ-009 busy  output  1  high while a frame is latched or shifting.
REQ-010 frame_done  output  1  one-cycle pulse when the final bit has been shifted.
REQ-011 frame_abort  output  1  one-cycle pulse when latch rises mid-frame.
REQ-012 bit_idx  output  5  index of the bit currently on data.

Function
REQ-013 latch and pulse shall each pass through SYNC_STAGES flops, then one edge-detect flop; all behaviour shall use the synchronized signals (latch_s, pulse_s).
REQ-014 The FSM shall have states IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: data = 1, busy = 0; a latch_s rising edge shall go to LOAD.
REQ-016 LOAD (latch_s high): every cycle, snapshot = buttons, bit_idx = 0, data = ~buttons[0]; pulse_s edges shall be ignored.
REQ-017 A latch_s falling edge in LOAD shall freeze the snapshot taken on the previous cycle and go to SHIFT.
REQ-018 SHIFT: each pulse_s rising edge shall increment bit_idx and drive data for the new index on the next cycle.
REQ-019 Wire value for index i: ~snapshot[i] for i < 12; 1 for 12 <= i < FRAME_BITS.
REQ-020 In SHIFT, a pulse_s rising edge with bit_idx = FRAME_BITS-1 shall go to DONE, assert frame_done for one cycle, set data = 0 and set bit_idx = FRAME_BITS.
REQ-021 DONE: data held 0, busy = 0; further pulse edges are ignored; bit_idx is held.
REQ-022 A latch_s rising edge shall go to LOAD from any state.
REQ-023 If that rising edge arrives in SHIFT, frame_abort shall pulse for one cycle in the same cycle LOAD is entered.
REQ-024 Simultaneous latch_s rising edge and pulse_s rising edge: latch wins; the pulse is discarded.
REQ-025 buttons changes after the latch falling edge shall not affect the frame in progress.
REQ-026 Latency: data shall reflect a pin-level pulse or latch edge exactly SYNC_STAGES+2 clk cycles after the edge; this holds when the input is stable at least 1 cycle before the edge.
REQ-027 busy = 1 exactly in LOAD and SHIFT.
REQ-028 bit_idx shall never exceed FRAME_BITS and shall not wrap.

Reset
REQ-029 rst_btn = 0 at a clk edge shall force, on that edge: state IDLE, data = 1, busy = 0, frame_done = 0, frame_abort = 0, bit_idx = 0, snapshot = 0, and all synchronizer and edge flops = 0.
REQ-030 Reset asserted mid-frame shall abort the frame without a frame_abort pulse.
REQ-031 After reset release, a latch already high shall be seen as a rising edge once synchronized.

Verification
REQ-032 buttons=12'h001 (B), latch high 10 cycles then low, 16 pulses (4 cycles high / 4 low) -> data sequence 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; then data=0 with frame_done pulsed once.
REQ-033 buttons=12'hA5A, full frame -> bits 0-11 = ~12'hA5A LSB-first, bits 12-15 = 1; buttons changed to 12'hFFF after latch falls -> no effect on the frame.
REQ-034 Latch reasserted after 5 pulses -> frame_abort pulses once; bit_idx=0; data = ~buttons[0]; the next full frame is correct.
REQ-035 Pulse edges while latch is high, and 3 extra pulses after DONE -> data, bit_idx and state unchanged.
REQ-036 Latch and pulse rising on the same clk cycle during SHIFT -> LOAD entered; bit_idx=0; no increment.
REQ-037 rst_btn=0 for 1 cycle during bit 7 -> data=1, busy=0, bit_idx=0 next cycle; no frame_done or frame_abort pulse.
